// File: rtl/shift_sequencer.sv
// Multi-cycle 1-bit-per-clock shift controller (SLL/SRL/SRA, optional ROL).
// Define SHIFT_SEQ_ROTATE_EN to build the rotate-left leg for op=11; otherwise op=11 shifts left logically.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shift_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [AMT_W-1:0]   cnt_r, cnt_s;
    logic [1:0]         op_q_r, op_q_s;
    logic [WIDTH-1:0]   shift_r, shift_s;
    logic               busy_r, done_r;
    logic               accept_s;

    function automatic logic [WIDTH-1:0] step_f(input logic [1:0] op_v, input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        case (op_v)
            2'b00: r = {x[WIDTH-2:0], 1'b0};
            2'b01: r = {1'b0, x[WIDTH-1:1]};
            2'b10: r = {x[WIDTH-1], x[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b11: r = {x[WIDTH-2:0], x[WIDTH-1]};
`endif
            default: r = {x[WIDTH-2:0], 1'b0};
        endcase
        return r;
    endfunction

    // Next-state, counter and datapath decode; a start seen mid-shift is dropped.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        op_q_s   = op_q_r;
        shift_s  = shift_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    shift_s  = data_in;
                    cnt_s    = amount;
                    op_q_s   = op;
                    if (amount == {AMT_W{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                shift_s = step_f(op_q_r, shift_r);
                cnt_s   = cnt_r - {{(AMT_W-1){1'b0}}, 1'b1};
                if (cnt_r == {{(AMT_W-1){1'b0}}, 1'b1}) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {AMT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {AMT_W{1'b0}};
            op_q_r  <= 2'b00;
            shift_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_q_r  <= op_q_s;
            shift_r <= shift_s;
            busy_r  <= (state_s == SHIFT);
            done_r  <= (state_s == DONE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign shift_out = shift_r;

    // accept_s is kept for readability of the decode; it has no other consumer.
    logic unused_s;
    assign unused_s = accept_s;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomised self-checking bench for shift_sequencer against a closed-form reference model.
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] data_in;
    logic [3:0]  amount;
    logic        busy;
    logic        done;
    logic [15:0] shift_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: the operand, op, total amount and steps taken so far.
    logic [15:0] m_data;
    logic [1:0]  m_op;
    int          m_k;
    int          m_j;
    logic        m_busy;
    logic        m_done;

    shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .data_in(data_in),
        .amount(amount), .busy(busy), .done(done), .shift_out(shift_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Value after j single-bit steps, computed directly as a j-bit shift.
    function automatic logic [15:0] ref_f(input logic [15:0] x, input logic [1:0] o, input int j);
        logic signed [15:0] s;
        logic [15:0]        r;
        s = x;
        case (o)
            2'b00: r = x << j;
            2'b01: r = x >> j;
            2'b10: r = 16'(s >>> j);
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b11: r = (j == 0) ? x : ((x << j) | (x >> (16 - j)));
`endif
            default: r = x << j;
        endcase
        return r;
    endfunction

    task automatic model_edge(input logic st, input logic [1:0] o, input logic [15:0] d,
                              input logic [3:0] a, input logic r);
        if (r) begin
            m_busy = 1'b0; m_done = 1'b0; m_data = 16'h0000; m_op = 2'b00; m_k = 0; m_j = 0;
        end else if (!m_busy && st) begin
            m_data = d; m_op = o; m_k = int'(a); m_j = 0;
            m_busy = (a != 4'd0);
            m_done = (a == 4'd0);
        end else if (m_busy) begin
            m_j++;
            m_done = (m_j == m_k);
            m_busy = !m_done;
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic cycle(input logic st, input logic [1:0] o, input logic [15:0] d,
                         input logic [3:0] a, input logic r);
        @(negedge clk);
        start = st; op = o; data_in = d; amount = a; rst = r;
        @(posedge clk);
        model_edge(st, o, d, a, r);
        #1;
        check_eq("busy", {31'd0, busy}, {31'd0, m_busy});
        check_eq("done", {31'd0, done}, {31'd0, m_done});
        check_eq("shift_out", {16'd0, shift_out}, {16'd0, ref_f(m_data, m_op, m_j)});
    endtask

    task automatic idle();
        cycle(1'b0, 2'b00, 16'h0000, 4'd0, 1'b0);
    endtask

    initial begin
        int pulses;
        start = 1'b0; op = 2'b00; data_in = 16'h0000; amount = 4'd0; rst = 1'b1;
        m_busy = 1'b0; m_done = 1'b0; m_data = 16'h0000; m_op = 2'b00; m_k = 0; m_j = 0;
        cycle(1'b0, 2'b00, 16'h0000, 4'd0, 1'b1);
        cycle(1'b1, 2'b01, 16'hFFFF, 4'd3, 1'b1);
        idle();

        // SLL by one
        cycle(1'b1, 2'b00, 16'd10, 4'd1, 1'b0);
        check_eq("sll_busy", {31'd0, busy}, 32'd1);
        idle();
        check_eq("sll_done", {31'd0, done}, 32'd1);
        check_eq("sll_res", {16'd0, shift_out}, 32'd20);
        idle();

        // SRA and SRL by four
        cycle(1'b1, 2'b10, 16'h8000, 4'd4, 1'b0);
        repeat (4) idle();
        check_eq("sra_res", {16'd0, shift_out}, 32'h0000F800);
        idle();
        cycle(1'b1, 2'b01, 16'h8000, 4'd4, 1'b0);
        repeat (4) idle();
        check_eq("srl_res", {16'd0, shift_out}, 32'h00000800);
        idle();

        // zero amount, then back-to-back accept in the DONE cycle
        cycle(1'b1, 2'b00, 16'd12, 4'd0, 1'b0);
        check_eq("zero_done", {31'd0, done}, 32'd1);
        check_eq("zero_busy", {31'd0, busy}, 32'd0);
        check_eq("zero_res", {16'd0, shift_out}, 32'd12);
        cycle(1'b1, 2'b00, 16'd12, 4'd2, 1'b0);
        idle();
        idle();
        check_eq("b2b_res", {16'd0, shift_out}, 32'd48);
        idle();

        // start while shifting is ignored
        cycle(1'b1, 2'b01, 16'hF0F0, 4'd5, 1'b0);
        pulses = 0;
        repeat (5) begin
            cycle(1'b1, 2'b00, 16'h1234, 4'd3, 1'b0);
            pulses += int'(done);
        end
        check_eq("ignore_res", {16'd0, shift_out}, 32'h00000787);
        repeat (3) begin
            idle();
            pulses += int'(done);
        end
        check_eq("ignore_pulses", pulses, 32'd1);

        // reset mid-shift
        cycle(1'b1, 2'b00, 16'hABCD, 4'd15, 1'b0);
        repeat (3) idle();
        cycle(1'b1, 2'b01, 16'h5555, 4'd2, 1'b1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_out", {16'd0, shift_out}, 32'd0);
        pulses = 0;
        repeat (20) begin
            idle();
            pulses += int'(done);
        end
        check_eq("rst_no_done", pulses, 32'd0);

        // op=11 on a wrapping operand
        cycle(1'b1, 2'b11, 16'h8001, 4'd1, 1'b0);
        idle();
`ifdef SHIFT_SEQ_ROTATE_EN
        check_eq("rol_res", {16'd0, shift_out}, 32'h00000003);
`else
        check_eq("op3_res", {16'd0, shift_out}, 32'h00000002);
`endif
        idle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 16'($urandom),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 60) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the 16-bit datapath.
- Accepts a shift request from the ID stage: operand, 4-bit amount and operation.
- Iterates a single-bit shift once per clock until the amount is exhausted.
- Presents the result with a one-cycle `done` pulse.
- `busy` is used by the pipeline control to stall issue while a shift is in flight.
- Replaces a wide combinational shifter on the critical path with a small sequenced one.

## Interface
- Parameters:
  - `WIDTH`, 16, operand/result width.
  - `AMT_W`, 4, shift-amount width (max amount 2^AMT_W − 1).
- Ports:
  - `clk`  input  1  rising-edge clock.
  - `rst`  input  1  synchronous, active-high reset.
  - `start`  input  1  request strobe; sampled every rising edge.
  - `op`  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL (see Configuration).
  - `data_in`  input  WIDTH  operand; captured on accept.
  - `amount`  input  AMT_W  shift count; captured on accept.
  - `busy`  output  1  high while in SHIFT.
  - `done`  output  1  one-cycle pulse: result valid.
  - `shift_out`  output  WIDTH  result register; holds until the next accept.

## Operation
- States: IDLE, SHIFT, DONE. All outputs are registered.
- Accept condition: `start` high while state is IDLE or DONE. `start` in SHIFT is ignored entirely; no queuing.
- On accept, capture `data_in` into `shift_out`, `amount` into the internal counter `cnt`, and `op` into the internal register `op_q`.
  - If `amount` == 0, go to DONE.
  - Otherwise go to SHIFT.
- In SHIFT, each edge applies a 1-bit step to `shift_out` according to `op_q` and decrements `cnt`:
  - SLL: `{x[W-2:0],0}`.
  - SRL: `{0,x[W-1:1]}`.
  - SRA: `{x[W-1],x[W-1:1]}`.
  - ROL: `{x[W-2:0],x[W-1]}`.
- When `cnt` == 1 on that edge, the step is applied and the state moves to DONE.
- DONE transitions:
  - Without accept, go to IDLE on the next edge.
  - With accept, start the new operation (back-to-back).
- `busy` = (state == SHIFT).
- `done` = (state == DONE).
- Bits shifted out are discarded; there is no carry/overflow output.
- Reset (any state, including mid-shift): state IDLE, `cnt` 0, `op_q` 00, `shift_out` 0, `busy` 0, `done` 0. Any in-flight operation is lost. `start` in the same cycle as `rst` is ignored.

## Timing
- Accepting edge = E0. Result is valid and `done`=1 in the cycle after edge E(k), where k = `amount`:
  - k=0: `done` in the cycle right after E0.
  - k=5: `done` after E5.
- `busy` is high during the cycles after E0..E(k−1) (k cycles total); it is never high for k=0.
- `done` is high for exactly one cycle per accepted request.
- Throughput: one request per k+1 cycles; k=0 back-to-back gives one result per cycle.
- `shift_out` changes every cycle during SHIFT. Consumers sample it only when `done`=1; after that it is stable until the next accept.

## Configuration
- Macro `SHIFT_SEQ_ROTATE_EN`:
  - Defined: op=11 performs rotate-left as above.
  - Undefined: op=11 is decoded as SLL. The rotate path and its mux leg are not synthesized.
- All other behaviour and timing are identical in both builds.

## Test plan
- SLL: `data_in`=10, `amount`=1, `op`=00 → `done` after E1, `shift_out`=20, `busy` high for 1 cycle.
- SRA: `data_in`=0x8000, `amount`=4, `op`=10 → `done` after E4, `shift_out`=0xF800; the same input with `op`=01 gives 0x0800.
- Zero amount, then back-to-back:
  - `data_in`=12, `amount`=0 → `done` after E0, `shift_out`=12, `busy` never high.
  - Second `start` asserted in the DONE cycle with `data_in`=12, `amount`=2, SLL → `done` 2 cycles later, `shift_out`=48.
- `start` during SHIFT with different operands → ignored. The original result is delivered unchanged, with exactly one `done` pulse.
- `rst` asserted mid-shift (`amount`=15, after E3) → next cycle `busy`=0, `done`=0, `shift_out`=0, and no `done` pulse follows.
- op=11, `data_in`=0x8001, `amount`=1:
  - With `SHIFT_SEQ_ROTATE_EN` → `shift_out`=0x0003.
  - Without it → `shift_out`=0x0002.
